// File: rtl/ps2_scancode_decoder.sv
// Assembles PS/2 set-2 scan-code bytes into make/break key events (E0-extended, E1 pause skipped)
// and queues them in a first-word-fall-through FIFO with an optional typematic-repeat filter.
module ps2_scancode_decoder #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter bit FILTER_REPEAT  = 1'b1
) (
  input  logic                    inclock,
  input  logic                    reset,
  input  logic [7:0]              ps2_key_data,
  input  logic                    ps2_key_pressed,
  input  logic                    evt_rd,
  output logic [9:0]              evt_data,
  output logic                    evt_valid,
  output logic [$clog2(DEPTH):0]  evt_count,
  output logic                    overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EXT    = 3'd1;
  localparam logic [2:0] ST_BRK    = 3'd2;
  localparam logic [2:0] ST_EXTBRK = 3'd3;
  localparam logic [2:0] ST_SKIP   = 3'd4;

  // Keyboard acknowledge / self-test / error bytes that never start a key sequence.
  function automatic logic is_discard(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic [CW-1:0] count_next(input logic [CW-1:0] c,
                                               input logic wr, input logic rd);
    case ({wr, rd})
      2'b10:   return c + CW'(1);
      2'b01:   return c - CW'(1);
      default: return c;
    endcase
  endfunction

  logic [2:0]    state, state_nxt;
  logic [2:0]    skip_cnt, skip_nxt;
  logic [TW-1:0] timer;
  logic          timeout;
  logic          emit, emit_ext, emit_rel;
  logic [8:0]    held_key;
  logic          held_vld;
  logic [8:0]    evt_key;
  logic          key_match, drop, push;

  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, do_pop, do_push;

  assign timeout = !ps2_key_pressed && (state != ST_IDLE) && (timer == TMO_LAST);

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_rel  = 1'b0;
    if (ps2_key_pressed) begin
      case (state)
        ST_IDLE: begin
          if (ps2_key_data == 8'hE0)      state_nxt = ST_EXT;
          else if (ps2_key_data == 8'hF0) state_nxt = ST_BRK;
          else if (ps2_key_data == 8'hE1) begin
            state_nxt = ST_SKIP;
            skip_nxt  = 3'd7;
          end else if (!is_discard(ps2_key_data)) emit = 1'b1;
        end
        ST_EXT: begin
          if (ps2_key_data == 8'hF0) state_nxt = ST_EXTBRK;
          else if (ps2_key_data != 8'hE0 && ps2_key_data != 8'hE1) begin
            emit      = 1'b1;
            emit_ext  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          emit      = 1'b1;
          emit_rel  = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXTBRK: begin
          emit      = 1'b1;
          emit_ext  = 1'b1;
          emit_rel  = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_SKIP: begin
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = ST_IDLE;
    end
  end

  // Repeat filter: a make matching the held key is typematic repeat and is suppressed.
  assign evt_key   = {emit_ext, ps2_key_data};
  assign key_match = held_vld && (held_key == evt_key);
  assign drop      = FILTER_REPEAT && !emit_rel && key_match;
  assign push      = emit && !drop;

  assign full    = (count == FULL_CNT);
  assign do_pop  = evt_rd && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge inclock) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      timer    <= '0;
      held_key <= '0;
      held_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      if (ps2_key_pressed || state == ST_IDLE || timeout) timer <= '0;
      else                                                timer <= timer + TW'(1);
      if (FILTER_REPEAT && emit) begin
        if (!emit_rel && !key_match) begin
          held_key <= evt_key;
          held_vld <= 1'b1;
        end else if (emit_rel && key_match) begin
          held_vld <= 1'b0;
        end
      end
    end
  end

  // FIFO: storage is data-only, pointers/count/overflow are control.
  always_ff @(posedge inclock) begin
    if (do_push) mem[wr_ptr] <= {evt_key, emit_rel} == '0 ? '0 : {emit_ext, emit_rel, ps2_key_data};
  end

  always_ff @(posedge inclock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next(count, do_push, do_pop);
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

  assign evt_valid = (count != '0);
  assign evt_count = count;
  assign evt_data  = evt_valid ? mem[rd_ptr] : 10'd0;

endmodule
